// File: rtl/lift_call_conditioner.sv
// Lift call-button conditioner: synchronise, debounce and latch three floor calls.
// Define LIFT_CALL_DEBOUNCE_EN to build the debounce counters; otherwise stable = sync output registered once.
module lift_call_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn0,
    input  logic btn1,
    input  logic btn2,
    input  logic bottom,
    input  logic middle_plus,
    input  logic middle_minus,
    input  logic top,
    input  logic enable,
    output logic call0,
    output logic call1,
    output logic call2,
    output logic pending
);

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES out of range 1..2^24");
    end

    logic [2:0] btn_raw;
    logic [2:0] at_floor;
    logic [2:0] clear;
    logic [2:0] rise;
    logic [2:0] sync1_q, sync1_d;
    logic [2:0] sync2_q, sync2_d;
    logic [2:0] stable_q, stable_d;
    logic [2:0] call_q, call_d;
    logic       pending_q, pending_d;

    assign btn_raw  = {btn2, btn1, btn0};
    assign at_floor = {top, middle_plus & middle_minus, bottom};

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        clear     = {3{~enable}} & at_floor;
        rise      = stable_d & ~stable_q;
        // Clear has priority over a same-cycle press on the same floor.
        call_d    = (call_q | rise) & ~clear;
        pending_d = |call_q;
    end

`ifdef LIFT_CALL_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    // Counter holds at CNT_MAX only for the cycle that flips stable, then clears.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            stable_d[i] = stable_q[i];
            cnt_d[i]    = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        stable_d = sync2_q;
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            call_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            call_q    <= call_d;
            pending_q <= pending_d;
        end
    end

    assign call0   = call_q[0];
    assign call1   = call_q[1];
    assign call2   = call_q[2];
    assign pending = pending_q;

endmodule

// File: tb/tb_lift_call_conditioner.sv
// Scoreboard bench for lift_call_conditioner with DEBOUNCE_CYCLES=4, valid with or without LIFT_CALL_DEBOUNCE_EN.
module tb_lift_call_conditioner;

    localparam int D = 4;
`ifdef LIFT_CALL_DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    localparam int LAT = DB_EN ? (2 + D) : 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] btn = 3'b000;
    logic       bottom = 1'b0, middle_plus = 1'b0, middle_minus = 1'b0, top = 1'b0;
    logic       enable = 1'b1;
    logic       call0, call1, call2, pending;
    logic [2:0] call_vec;

    int checks = 0;
    int errors = 0;

    assign call_vec = {call2, call1, call0};

    lift_call_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset),
        .btn0(btn[0]), .btn1(btn[1]), .btn2(btn[2]),
        .bottom(bottom), .middle_plus(middle_plus), .middle_minus(middle_minus), .top(top),
        .enable(enable),
        .call0(call0), .call1(call1), .call2(call2), .pending(pending)
    );

    always #10 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each button is a delay line plus a "how long has it disagreed" run length.
    logic [3:0] exp_q[$];
    logic [2:0] m_s1, m_s2, m_stable, m_call;
    logic       m_pend;
    int         m_run [3];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_call = '0; m_pend = 1'b0;
            for (int i = 0; i < 3; i++) m_run[i] = 0;
            exp_q.delete();
        end else begin
            logic [2:0] new_st, new_call, floor_here;
            logic       new_pend;
            floor_here = {top, middle_plus & middle_minus, bottom};
            for (int i = 0; i < 3; i++) begin
                if (DB_EN) begin
                    m_run[i] = (m_s2[i] != m_stable[i]) ? m_run[i] + 1 : 0;
                    new_st[i] = (m_run[i] >= D) ? m_s2[i] : m_stable[i];
                    if (m_run[i] >= D) m_run[i] = 0;
                end else begin
                    new_st[i] = m_s2[i];
                end
                if (!enable && floor_here[i]) new_call[i] = 1'b0;
                else new_call[i] = m_call[i] | (new_st[i] & ~m_stable[i]);
            end
            new_pend = |m_call;
            exp_q.push_back({new_call, new_pend});
            m_stable = new_st;
            m_call = new_call;
            m_pend = new_pend;
            m_s2 = m_s1;
            m_s1 = btn;
        end
    end

    always @(negedge clock) begin
        if (!reset && exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check("scoreboard {call2,call1,call0,pending}", {28'd0, call_vec, pending}, {28'd0, e});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset(input logic [2:0] b);
        @(negedge clock);
        reset = 1'b1;
        btn = 3'b000; bottom = 0; middle_plus = 0; middle_minus = 0; top = 0; enable = 1;
        cycles(2);
        check("reset outputs", {28'd0, call_vec, pending}, 32'd0);
        reset = 1'b0;
        btn = b;
    endtask

    task automatic wait_call(input int idx, input int exp_edges, input string name);
        int n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (call_vec[idx]) begin
                n = k;
                break;
            end
        end
        check(name, n, exp_edges);
    endtask

    task automatic press(input int idx, input int n);
        btn[idx] = 1'b1;
        cycles(n);
        btn[idx] = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Scenario 1: held press latency and pending one edge later.
        do_reset(3'b010);
        wait_call(1, LAT, "s1 call1 latency");
        @(posedge clock); #1;
        check("s1 pending", {31'd0, pending}, 32'd1);
        check("s1 call0/call2", {30'd0, call2, call0}, 32'd0);

        // Scenario 2: short glitch versus a proper press.
        do_reset(3'b000);
        cycles(1);
        press(2, 3);
        cycles(10);
        check("s2 short pulse call2", {31'd0, call2}, {31'd0, !DB_EN});
        press(2, 6);
        cycles(6);
        check("s2 long press call2", {31'd0, call2}, 32'd1);

        // Scenario 3: floor-0 clear leaves other floors alone.
        do_reset(3'b000);
        btn = 3'b101;
        cycles(8);
        btn = 3'b000;
        cycles(8);
        check("s3 calls latched", {29'd0, call_vec}, 32'b101);
        bottom = 1; enable = 0;
        @(posedge clock); #1;
        check("s3 call0 cleared", {31'd0, call0}, 32'd0);
        check("s3 call1/call2 kept", {30'd0, call2, call1}, 32'b10);
        @(negedge clock);
        bottom = 0; enable = 1;

        // Scenario 4: press at a stopped floor never latches; same floor while moving does.
        do_reset(3'b000);
        top = 1; enable = 0;
        press(2, 10);
        cycles(10);
        check("s4 clear wins call2", {31'd0, call2}, 32'd0);
        enable = 1;
        press(2, 10);
        cycles(4);
        check("s4 moving call2", {31'd0, call2}, 32'd1);
        top = 0;

        // Scenario 5: held button through a clear does not re-arm.
        do_reset(3'b010);
        cycles(10);
        check("s5 call1 latched", {31'd0, call1}, 32'd1);
        middle_plus = 1; middle_minus = 1; enable = 0;
        cycles(1);
        middle_plus = 0; middle_minus = 0; enable = 1;
        cycles(1);
        check("s5 call1 cleared", {31'd0, call1}, 32'd0);
        cycles(12);
        check("s5 still held call1", {31'd0, call1}, 32'd0);
        btn[1] = 0;
        cycles(6);
        btn[1] = 1;
        cycles(10);
        check("s5 re-press call1", {31'd0, call1}, 32'd1);

        // Scenario 6: 15 ns async reset mid-debounce with calls latched.
        do_reset(3'b000);
        btn = 3'b101;
        cycles(8);
        btn = 3'b000;
        cycles(8);
        btn[1] = 1;
        cycles(3);
        @(posedge clock);
        #3 reset = 1'b1;
        #1 check("s6 async reset outputs", {28'd0, call_vec, pending}, 32'd0);
        #14 reset = 1'b0;
        wait_call(1, LAT, "s6 call1 after reset");
        check("s6 call0/call2 gone", {30'd0, call2, call0}, 32'd0);

        // Randomised traffic checked only by the scoreboard.
        do_reset(3'b000);
        for (int c = 0; c < 800; c++) begin
            @(negedge clock);
            for (int i = 0; i < 3; i++)
                if ($urandom_range(7) == 0) btn[i] = ~btn[i];
            if ($urandom_range(3) == 0) bottom = $urandom_range(1);
            if ($urandom_range(3) == 0) middle_plus = $urandom_range(1);
            if ($urandom_range(3) == 0) middle_minus = $urandom_range(1);
            if ($urandom_range(3) == 0) top = $urandom_range(1);
            if ($urandom_range(2) == 0) enable = $urandom_range(1);
            if ($urandom_range(299) == 0) begin
                #4 reset = 1'b1;
                #15 reset = 1'b0;
            end
        end
        cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lift_call_conditioner.md
LIFT_CALL_CONDITIONER -- requirements
Module: lift_call_conditioner

Interface
REQ-001 The block SHALL have one parameter, DEBOUNCE_CYCLES, default 1000000, giving the press/release stability time in clock cycles (20 ms at 50 MHz), legal range 1 to 2^24.
REQ-002 The block SHALL have the port clock, input, 1 bit: the single 50 MHz system clock; all state changes on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have the port btn0, btn1, btn2, input, 1 bit each: raw asynchronous floor call buttons, 1 = pressed.
REQ-005 The block SHALL have the port bottom, input, 1 bit: lift car at floor 0 sensor (synchronous to clock).
REQ-006 The block SHALL have the port middle_plus and middle_minus, input, 1 bit each: middle sensors; floor 1 is the state where both are 1.
REQ-007 The block SHALL have the port top, input, 1 bit: lift car at floor 2 sensor.
REQ-008 The block SHALL have the port enable, input, 1 bit: motor enable from the controller; 0 = car stopped.
REQ-009 The block SHALL have the port call0, call1, call2, output, 1 bit each: latched, held call requests feeding the lift controller.
REQ-010 The block SHALL have the port pending, output, 1 bit: OR of call0..call2, registered.

Function
REQ-011 Each btnN SHALL pass through a two-flop synchroniser before any other logic uses it.
REQ-012 Per button, a debounced level stableN SHALL flip only after the synchronised input has differed from stableN for DEBOUNCE_CYCLES consecutive cycles; the counter SHALL clear whenever the two are equal.
REQ-013 The counter width SHALL be clog2(DEBOUNCE_CYCLES)+1 bits; it SHALL never wrap, and it SHALL saturate at DEBOUNCE_CYCLES-1 before the flip.
REQ-014 A 0->1 transition of stableN SHALL set callN on the same clock edge; a 1->0 transition SHALL have no effect on callN.
REQ-015 Latency: a clean press held from edge 0 SHALL raise callN on rising edge 2+DEBOUNCE_CYCLES.
REQ-016 The clear condition for callN SHALL be: enable=0 and the car is at floor N (floor 0 = bottom, floor 1 = middle_plus&middle_minus, floor 2 = top).
REQ-017 When the clear condition holds, callN SHALL go to 0 on the next edge.
REQ-018 Simultaneous set and clear of the same floor SHALL resolve as clear wins.
REQ-019 Calls SHALL be independent: set and clear on different floors in the same cycle SHALL both take effect.
REQ-020 A button held continuously through a clear SHALL NOT re-set its call; a new release (debounced) followed by a press is required.
REQ-021 Input pulses shorter than DEBOUNCE_CYCLES cycles after synchronisation SHALL be ignored.
REQ-022 pending SHALL equal the OR of call0..call2, delayed by one cycle.

Reset
REQ-023 While reset=1, the synchronisers, stableN, the counters, call0..call2 and pending SHALL all be 0, independent of clock.
REQ-024 Reset asserted mid-debounce or with calls latched SHALL discard all state; after release, a still-pressed button SHALL be treated as a new press, taking the full REQ-015 latency.

Configuration
REQ-025 The macro LIFT_CALL_DEBOUNCE_EN SHALL enable the feature when defined: debounce per REQ-012 and REQ-013.
REQ-026 When LIFT_CALL_DEBOUNCE_EN is undefined, the debounce counters SHALL NOT be built, DEBOUNCE_CYCLES SHALL be ignored, and stableN SHALL be the synchroniser output registered once. This gives a fixed latency of rising edge 3.

Verification
REQ-027 The bench SHALL run each scenario below with DEBOUNCE_CYCLES=4.
REQ-028 Scenario 1: btn1 held high from edge 0, enable=1 -> call1=1 at edge 6, pending=1 at edge 7, call0=call2=0.
REQ-029 Scenario 2: btn2 high for 3 cycles only -> call2 stays 0; then btn2 high for 6 cycles -> call2=1.
REQ-030 Scenario 3: call0 latched, then bottom=1 and enable=0 -> call0=0 on the next edge; call1 and call2 are unchanged.
REQ-031 Scenario 4: car at top with enable=0, btn2 pressed -> call2 never asserts (clear wins); the same press with enable=1 -> call2=1.
REQ-032 Scenario 5: call1 latched and btn1 still held, floor-1 clear occurs -> call1=0 and stays 0 until btn1 is released for 4+ cycles and pressed again.
REQ-033 Scenario 6: reset pulsed for 15 ns while call0/call2 are set and btn1 is mid-debounce -> all outputs are 0 immediately; a held btn1 gives call1=1 six edges after reset release. Also run with LIFT_CALL_DEBOUNCE_EN undefined -> Scenario 1 gives call1 at edge 3.
